cdc_mbit_handshake: RTL and testbench

Multi-bit clock-domain-crossing block that carries a WIDTH-bit word from the aclk domain to the bclk domain with a four-phase req/ack handshake, one word per round trip, for any clock ratio. It replaces single-bit pulse stretching on the LED PHY control path where register words, not single strobes, must cross, and it reports back-pressure and lost words to the source.

---
 rtl/cdc_pkg.sv | 5 +
 rtl/cdc_sync_bit.sv | 15 +
 rtl/cdc_mbit_handshake.sv | 97 +++++++++
 tb/tb_cdc_mbit_handshake.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/cdc_pkg.sv
// cdc_pkg: shared types and limits for the multi-bit handshake crossing.
package cdc_pkg;
    typedef enum logic [1:0] {INIT, IDLE, REQ, ACKLO} src_state_e;
    localparam int SYNC_STAGES_MIN = 2;
endpackage

// File: rtl/cdc_sync_bit.sv
// cdc_sync_bit: STAGES-deep single-bit synchroniser into the clk domain.
module cdc_sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] sr;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) sr <= '0;
        else sr <= {sr[STAGES-2:0], d};
    assign q = sr[STAGES-1];
endmodule

// File: rtl/cdc_mbit_handshake.sv
// cdc_mbit_handshake: WIDTH-bit aclk->bclk word transfer over a four-phase req/ack handshake.
// Define CDC_HSK_PEND_EN to add a one-word pending slot on the source side.
module cdc_mbit_handshake
    import cdc_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             aclk,
    input  logic             arst_n,
    input  logic             bclk,
    input  logic             brst_n,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    output logic             a_busy,
    output logic             a_drop,
    output logic             b_valid,
    output logic [WIDTH-1:0] b_data
);
    localparam int CW = $clog2(SYNC_STAGES + 1);

    if (SYNC_STAGES < SYNC_STAGES_MIN || WIDTH < 1) begin : g_bad_param
        $error("cdc_mbit_handshake: SYNC_STAGES must be >= %0d and WIDTH >= 1", SYNC_STAGES_MIN);
    end

    src_state_e       state;
    logic [CW-1:0]    cnt;
    logic             req, ack_s, req_s, req_s_d;
    logic [WIDTH-1:0] hold;
`ifdef CDC_HSK_PEND_EN
    logic [WIDTH-1:0] pend;
    logic             pend_full;
    assign a_busy = pend_full || state == INIT;
`else
    assign a_busy = state != IDLE;
`endif

    always_ff @(posedge aclk or negedge arst_n)
        if (!arst_n) begin
            state  <= INIT;
            cnt    <= '0;
            req    <= 1'b0;
            hold   <= '0;
            a_drop <= 1'b0;
`ifdef CDC_HSK_PEND_EN
            pend      <= '0;
            pend_full <= 1'b0;
`endif
        end else begin
            a_drop <= a_valid && a_busy;
`ifdef CDC_HSK_PEND_EN
            if (a_valid && !pend_full && (state == REQ || state == ACKLO)) begin
                pend      <= a_data;
                pend_full <= 1'b1;
            end
`endif
            case (state)
                // a stale ack from a destination still mid-transfer must drain first
                INIT: if (cnt != CW'(SYNC_STAGES)) cnt <= cnt + CW'(1);
                      else if (!ack_s) state <= IDLE;
                IDLE: if (a_valid) begin
                    hold  <= a_data;
                    req   <= 1'b1;
                    state <= REQ;
                end
                REQ: if (ack_s) begin
                    req   <= 1'b0;
                    state <= ACKLO;
                end
                ACKLO: if (!ack_s) begin
`ifdef CDC_HSK_PEND_EN
                    req       <= pend_full || a_valid;
                    state     <= (pend_full || a_valid) ? REQ : IDLE;
                    pend_full <= 1'b0;
                    if (pend_full || a_valid) hold <= pend_full ? pend : a_data;
`else
                    state <= IDLE;
`endif
                end
            endcase
        end

    cdc_sync_bit #(.STAGES(SYNC_STAGES)) u_req_sync (.clk(bclk), .rst_n(brst_n), .d(req), .q(req_s));
    cdc_sync_bit #(.STAGES(SYNC_STAGES)) u_ack_sync (.clk(aclk), .rst_n(arst_n), .d(req_s), .q(ack_s));

    // hold is frozen for as long as req_s is high, so capturing it here is skew-free
    always_ff @(posedge bclk or negedge brst_n)
        if (!brst_n) begin
            req_s_d <= 1'b0;
            b_valid <= 1'b0;
            b_data  <= '0;
        end else begin
            req_s_d <= req_s;
            b_valid <= req_s && !req_s_d;
            if (req_s && !req_s_d) b_data <= hold;
        end
endmodule

// File: tb/tb_cdc_mbit_handshake.sv
// tb_cdc_mbit_handshake: randomized self-checking bench with a word-level scoreboard.
// Expectations follow CDC_HSK_PEND_EN when it is defined.
module tb_cdc_mbit_handshake;
`ifdef CDC_HSK_PEND_EN
    localparam bit PEND = 1'b1;
`else
    localparam bit PEND = 1'b0;
`endif
    logic aclk = 0, bclk = 0, arst_n = 0, brst_n = 0, a_valid = 0;
    logic [7:0] a_data = 0;
    logic a_busy, a_drop, b_valid;
    logic [7:0] b_data;
    int ha = 10, hb = 40;
    int n_chk = 0, n_fail = 0, n_deliv = 0, n_extra = 0, n_drop = 0, exp_drop = 0, exp_tot = 0;
    logic [7:0] exp_q[$];

    cdc_mbit_handshake #(.WIDTH(8), .SYNC_STAGES(2)) dut (
        .aclk(aclk), .arst_n(arst_n), .bclk(bclk), .brst_n(brst_n),
        .a_valid(a_valid), .a_data(a_data), .a_busy(a_busy), .a_drop(a_drop),
        .b_valid(b_valid), .b_data(b_data)
    );

    always #(ha) aclk = ~aclk;
    always #(hb) bclk = ~bclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge bclk)
        if (brst_n && b_valid) begin
            n_deliv++;
            if (exp_q.size() == 0) n_extra++;
            else chk("b_data", b_data, exp_q.pop_front());
        end

    always @(negedge aclk) if (arst_n && a_drop) n_drop++;

    task automatic expect_word(input logic [7:0] d);
        exp_q.push_back(d);
        exp_tot++;
    endtask

    task automatic send(input logic [7:0] d);
        @(posedge aclk); #1 a_valid = 1; a_data = d;
        @(posedge aclk); #1 a_valid = 0;
    endtask

    task automatic wait_deliv();
        for (int i = 0; i < 3000 && n_deliv < exp_tot; i++) @(posedge aclk);
        chk("deliv_cnt", n_deliv, exp_tot);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 3000 && a_busy; i++) @(negedge aclk);
        chk("idle", a_busy, 0);
    endtask

    task automatic settle();
        repeat (100) @(posedge aclk);
        chk("n_deliv_settled", n_deliv, exp_tot);
        chk("n_drop", n_drop, exp_drop);
        chk("busy_settled", a_busy, 0);
    endtask

    initial begin
        repeat (3) @(negedge aclk);
        chk("rst_busy", a_busy, 1);
        chk("rst_drop", a_drop, 0);
        chk("rst_bvalid", b_valid, 0);
        chk("rst_bdata", b_data, 0);
        arst_n = 1; brst_n = 1;
        // a word offered during INIT is dropped
        send(8'hFF);
        exp_drop++;
        chk("init_busy", a_busy, 1);
        chk("init_bdata", b_data, 0);
        wait_idle();
        settle();
        // single word from idle
        send(8'hA5);
        expect_word(8'hA5);
        chk("busy_after_send", a_busy, PEND ? 0 : 1);
        wait_deliv();
        settle();
        // second word while busy
        send(8'hA5);
        expect_word(8'hA5);
        repeat ($urandom_range(3)) @(posedge aclk);
        send(8'h3C);
        if (PEND) expect_word(8'h3C); else exp_drop++;
        wait_deliv();
        settle();
        // three back-to-back words
        @(posedge aclk); #1 a_valid = 1; a_data = 8'h01;
        @(posedge aclk); #1 a_data = 8'h02;
        @(posedge aclk); #1 a_data = 8'h03;
        @(posedge aclk); #1 a_valid = 0;
        expect_word(8'h01);
        if (PEND) begin expect_word(8'h02); exp_drop += 1; end else exp_drop += 2;
        wait_deliv();
        settle();
        // slow source, fast destination: random words one round trip apart
        ha = 50; hb = 5;
        repeat (4) @(posedge aclk);
        for (int k = 0; k < 100; k++) begin
            logic [7:0] d;
            d = 8'($urandom);
            send(d);
            expect_word(d);
            for (int i = 0; i < 3000 && n_deliv < exp_tot; i++) @(posedge aclk);
            for (int i = 0; i < 3000 && a_busy; i++) @(negedge aclk);
            repeat ($urandom_range(2)) @(posedge aclk);
        end
        wait_deliv();
        settle();
        // source reset while req is high, before the destination samples it
        ha = 10; hb = 40;
        repeat (4) @(posedge aclk);
        @(posedge bclk);
        @(posedge aclk); #1 a_valid = 1; a_data = 8'h77;
        @(posedge aclk); #1 a_valid = 0; arst_n = 0;
        #4 arst_n = 1;
        for (int i = 0; i < 2; i++) begin
            @(negedge aclk);
            chk("rst_init_busy", a_busy, 1);
        end
        wait_idle();
        settle();
        send(8'h5A);
        expect_word(8'h5A);
        wait_deliv();
        settle();
        chk("hold_bdata", b_data, 8'h5A);
        chk("n_extra", n_extra, 0);
        chk("q_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
